tt_input_conditioner: RTL
=========================

# tt_input_conditioner

Per-bit input conditioner sitting directly upstream of the user logic in the Tiny Tapeout top (`tt_um_*`). It takes raw `ui_in` pad bits and produces three outputs for the combinational logic to consume:
- clean, debounced levels;
- one-cycle rising-edge pulses;
- one-cycle falling-edge pulses.

Each bit is synchronised through two flops, then debounced with a per-bit saturating counter. Unsynchronised switches and buttons never reach `uo_out` logic directly.

## Interface
Parameters:
- `WIDTH`, default 8: number of conditioned bits.
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised bit must disagree with `dout` before `dout` flips. Legal range is 2..256. Counter width is `$clog2(DEBOUNCE_CYCLES)`.

Ports:
- `clk`  in  1: single clock; all flops are on the rising edge.
- `rst`  in  1: synchronous reset, active-high. The top drives it as `~rst_n`.
- `ena`  in  1: design-enable from the top. When low, the debounce state freezes.
- `din`  in  WIDTH: raw, asynchronous input bits (`ui_in`).
- `dout`  out  WIDTH: debounced level per bit.
- `rise`  out  WIDTH: one-cycle pulse when a `dout` bit goes 0→1.
- `fall`  out  WIDTH: one-cycle pulse when a `dout` bit goes 1→0.
- `busy`  out  1: high while any bit's debounce counter is non-zero.

## Operation
- **Synchroniser:** `din` → `s1` → `s2`, per bit. It runs every cycle regardless of `ena`.
- **Per-bit debounce**, with `cnt[i]` and `dout[i]`, evaluated each cycle when `ena` is 1:
  - If `s2[i] == dout[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `dout[i] <= s2[i]`, `cnt[i] <= 0`, and the matching `rise[i]`/`fall[i]` pulse is registered.
  - Else: `cnt[i] <= cnt[i] + 1`.
- **Glitch rejection:** any mismatch run shorter than `DEBOUNCE_CYCLES` cycles at `s2` resets the counter. `dout` does not change.
- **Bit independence:** all bits are independent. Several bits may flip, and several pulses may assert, in the same cycle.
- **`ena` low:**
  - `cnt` and `dout` hold their values.
  - `rise`/`fall` are forced to 0 on the next edge.
  - Counting resumes where it left off when `ena` returns high.
- **`busy`:** registered OR-reduction of the next-state `cnt != 0` over all bits.
- **Reset:** `rst` high on an edge clears `s1`, `s2`, all `cnt`, `dout`, `rise`, `fall` and `busy` to 0. This includes a reset mid-debounce: no pulse is emitted for a bit whose count was in progress. `rst` has priority over `ena`.

## Timing
- All outputs are registered. Reset value of every output is 0.
- **Latency:** `din[i]` changes before edge 1 and stays stable. Then:
  - `s2[i]` changes after edge 2.
  - `dout[i]` flips after edge `2 + DEBOUNCE_CYCLES`.
  - `rise[i]`/`fall[i]` is high for exactly the cycle following that same edge.
- **Pulse rules:**
  - Pulses never last more than 1 cycle.
  - `rise[i]` and `fall[i]` are never high together.
  - The minimum spacing between two pulses on one bit is `DEBOUNCE_CYCLES` cycles.
- **Counter:** it never exceeds `DEBOUNCE_CYCLES-1`. No wrap-around is possible, because the flip and the clear happen on the same edge.
- **After reset deasserts:** a `din` bit held at 1 produces `rise` after `2 + DEBOUNCE_CYCLES` edges.

## Configuration
Macro: `TT_INPUT_COND_EDGE_EN`.
- **Defined:** `rise` and `fall` are generated as described above.
- **Undefined:**
  - `rise` and `fall` are tied to constant 0.
  - Their pulse flops are not instantiated.
  - `dout`, `busy` and all timing are unchanged.

## Test plan
All scenarios use `WIDTH=8`, `DEBOUNCE_CYCLES=4`, with `TT_INPUT_COND_EDGE_EN` defined unless stated.
1. **Reset values.** Hold `rst`=1 for 3 cycles with `din`=8'hFF → `dout`=0, `rise`=`fall`=0, `busy`=0. Release `rst` → `dout`=8'hFF after edge 6, and `rise`=8'hFF for exactly one cycle.
2. **Clean step.** Set `din[0]` 0→1 and hold → `dout[0]`=1 after edge 6 and `rise[0]` pulses once. Then set `din[0]` 1→0 → `fall[0]` pulses once, 6 edges later.
3. **Glitch rejection.** Drive 3-cycle high pulses on `din[3]`, separated by 2 low cycles, for 40 cycles → `dout[3]` stays 0 and `rise` stays 0. `busy` toggles high during each pulse.
4. **`ena` freeze.** Start a change on `din[5]`, deassert `ena` after 2 counted cycles, hold it low 10 cycles, then reassert → `dout[5]` flips 2 cycles after `ena` returns. No pulse appears while `ena`=0.
5. **Mid-debounce reset and simultaneous bits.** Change `din` 8'h00→8'hA5, then assert `rst` 1 cycle at edge 4 → no pulse, `dout`=0. After release, `dout`=8'hA5 after edge 6 and `rise`=8'hA5 in a single cycle.
6. **Macro absent.** Rebuild without `TT_INPUT_COND_EDGE_EN` and repeat scenario 2 → `dout` timing is identical, and `rise`/`fall` remain 0 throughout.

Source files
------------

// File: rtl/tt_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tt_input_conditioner
// Purpose  : Per-bit input conditioner for raw Tiny Tapeout pad inputs.
//            Each bit passes through a two-flop synchroniser and then a
//            saturating debounce counter. The block produces a clean level
//            and, optionally, one-cycle rising/falling edge pulses.
// Ports    : clk   - single clock, rising edge
//            rst   - synchronous reset, active high, has priority over ena
//            ena   - debounce enable; when low, counters and levels freeze
//            din   - raw asynchronous input bits [WIDTH]
//            dout  - debounced level per bit [WIDTH]
//            rise  - one-cycle pulse on a dout 0->1 transition [WIDTH]
//            fall  - one-cycle pulse on a dout 1->0 transition [WIDTH]
//            busy  - high while any debounce counter is non-zero
// Config   : TT_INPUT_COND_EDGE_EN - when defined, rise/fall pulses are
//            generated; when undefined they are tied to 0 and no pulse
//            flops exist.
// Revision : 1.0 - initial release
// ============================================================================
module tt_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             busy
);

    localparam int             c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]   r_s1;
    logic [WIDTH-1:0]   r_s2;
    logic [WIDTH-1:0]   r_dout;
    logic               r_busy;
    logic [c_cnt_w-1:0] r_cnt     [WIDTH];

    logic [c_cnt_w-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0]   w_flip;
    logic [WIDTH-1:0]   w_cnt_nz;

    // Per-bit debounce next-state. A flip happens on the edge where the
    // mismatch has already been seen DEBOUNCE_CYCLES-1 times, so the counter
    // clears on that same edge and can never wrap.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic w_mismatch;

            assign w_mismatch    = r_s2[gi] ^ r_dout[gi];
            assign w_flip[gi]    = ena & w_mismatch & (r_cnt[gi] == c_cnt_max);
            assign w_cnt_nxt[gi] = !ena                      ? r_cnt[gi] :
                                   (!w_mismatch || w_flip[gi]) ? '0 :
                                   r_cnt[gi] + 1'b1;
            assign w_cnt_nz[gi]  = |w_cnt_nxt[gi];
        end
    endgenerate

    // The synchroniser runs regardless of ena; only the debounce state
    // freezes when ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_dout <= '0;
            r_busy <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= din;
            r_s2   <= r_s1;
            // A flip always moves dout toward s2, so toggling is equivalent.
            r_dout <= r_dout ^ w_flip;
            r_busy <= |w_cnt_nz;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign dout = r_dout;
    assign busy = r_busy;

`ifdef TT_INPUT_COND_EDGE_EN
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    // w_flip already carries ena, so pulses drop to 0 while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_flip & r_s2;
            r_fall <= w_flip & ~r_s2;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule
`default_nettype wire
